// File: rtl/sparse_pkg.sv
// Shared definitions for the sparse pair compactor: default number format
// and the controller state encoding.
package sparse_pkg;

  localparam int IL_DEF = 8;
  localparam int FL_DEF = 12;
  localparam int DW     = IL_DEF + FL_DEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sparse_elem_sel.sv
// Selects one DW-wide element from a packed N-element vector by index;
// an index at or beyond N yields zero.
module sparse_elem_sel #(
  parameter int DW = 20,
  parameter int N  = 16,
  parameter int IW = 5
) (
  input  logic [N*DW-1:0] i_vec,
  input  logic [IW-1:0]   i_idx,
  output logic [DW-1:0]   o_elem
);

  always_comb begin
    o_elem = '0;
    for (int k = 0; k < N; k++) begin
      if (i_idx == IW'(k)) begin
        o_elem = i_vec[k*DW +: DW];
      end
    end
  end

endmodule

// File: rtl/sparse_pair_compactor.sv
// Walks a position mask one bit per cycle and packs matching
// (activation, weight) element pairs densely into the output vectors.
module sparse_pair_compactor
  import sparse_pkg::*;
#(
  parameter int IL  = IL_DEF,
  parameter int FL  = FL_DEF,
  parameter int N   = 16,
  parameter int LEN = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N*(IL+FL)-1:0]     i_vec,
  input  logic [N*(IL+FL)-1:0]     w_vec,
  input  logic [LEN-1:0]           o_mask,
  input  logic [LEN-1:0]           xor_i_mask,
  input  logic [LEN-1:0]           xor_w_mask,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [N*(IL+FL)-1:0]     oi_vec,
  output logic [N*(IL+FL)-1:0]     ow_vec,
  output logic [$clog2(N+1)-1:0]   o_count,
  output logic                     overflow,
  output logic                     out_valid,
  input  logic                     out_ready,
  output state_t                   o_dbg_state
);

  localparam int EW = IL + FL;
  localparam int CW = $clog2(N+1);
  localparam int MW = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [CW-1:0] N_C    = CW'(N);
  localparam logic [MW-1:0] M_LAST = MW'(LEN-1);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; in_ready is high only in IDLE, out_valid only in DONE, and
  // DONE holds every output stable until out_ready.

  state_t             r_state;
  logic [N*EW-1:0]    r_i_vec;
  logic [N*EW-1:0]    r_w_vec;
  logic [LEN-1:0]     r_omask;
  logic [LEN-1:0]     r_xi;
  logic [LEN-1:0]     r_xw;
  logic [MW-1:0]      r_m;
  logic [CW-1:0]      r_i;
  logic [CW-1:0]      r_w;
  logic [CW-1:0]      r_slot;
  logic [N*EW-1:0]    r_oi;
  logic [N*EW-1:0]    r_ow;
  logic               r_overflow;

  logic [EW-1:0]      w_i_elem;
  logic [EW-1:0]      w_w_elem;
  logic               w_hit;
  logic               w_pair_ok;
  logic [LEN-1:0]     w_above;
  logic               w_last;

  sparse_elem_sel #(.DW(EW), .N(N), .IW(CW)) u_sel_i (
    .i_vec  (r_i_vec),
    .i_idx  (r_i),
    .o_elem (w_i_elem)
  );

  sparse_elem_sel #(.DW(EW), .N(N), .IW(CW)) u_sel_w (
    .i_vec  (r_w_vec),
    .i_idx  (r_w),
    .o_elem (w_w_elem)
  );

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v >= N_C) ? N_C : v + CW'(1);
  endfunction

  assign w_hit     = r_omask[r_m];
  assign w_pair_ok = (r_i < N_C) && (r_w < N_C) && (r_slot < N_C);
  // Early exit once no pair-producing position remains above the current one.
  assign w_above   = (r_omask >> r_m) >> 1;
  assign w_last    = (r_m == M_LAST) || (w_above == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_i_vec    <= '0;
      r_w_vec    <= '0;
      r_omask    <= '0;
      r_xi       <= '0;
      r_xw       <= '0;
      r_m        <= '0;
      r_i        <= '0;
      r_w        <= '0;
      r_slot     <= '0;
      r_oi       <= '0;
      r_ow       <= '0;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_i_vec    <= i_vec;
            r_w_vec    <= w_vec;
            r_omask    <= o_mask;
            r_xi       <= xor_i_mask;
            r_xw       <= xor_w_mask;
            r_m        <= '0;
            r_i        <= '0;
            r_w        <= '0;
            r_slot     <= '0;
            r_oi       <= '0;
            r_ow       <= '0;
            r_overflow <= 1'b0;
            r_state    <= SCAN;
          end
        end
        SCAN: begin
          if (w_hit) begin
            if (w_pair_ok) begin
              for (int k = 0; k < N; k++) begin
                if (r_slot == CW'(k)) begin
                  r_oi[k*EW +: EW] <= w_i_elem;
                  r_ow[k*EW +: EW] <= w_w_elem;
                end
              end
            end else begin
              r_overflow <= 1'b1;
            end
            r_i    <= sat_inc(r_i);
            r_w    <= sat_inc(r_w);
            r_slot <= w_pair_ok ? sat_inc(r_slot) : r_slot;
          end else begin
            if (r_xi[r_m]) r_i <= sat_inc(r_i);
            if (r_xw[r_m]) r_w <= sat_inc(r_w);
          end
          if (w_last) begin
            r_state <= DONE;
          end else begin
            r_m <= r_m + MW'(1);
          end
        end
        DONE: begin
          if (out_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready    = (r_state == IDLE);
  assign out_valid   = (r_state == DONE);
  assign oi_vec      = r_oi;
  assign ow_vec      = r_ow;
  assign o_count     = r_slot;
  assign overflow    = r_overflow;
  assign o_dbg_state = r_state;

endmodule
